// File: rtl/mem_arbiter_if.sv
// CPU-side fetch/data request ports plus the shared single-port memory bus.
// The arbiter connects as the slave; the core and memory side is the master.
interface mem_arbiter_if #(
    parameter int XLEN = 32
);
    logic            i_inst_req;
    logic [XLEN-1:0] i_inst_addr;
    logic            i_data_req;
    logic [XLEN-1:0] i_data_addr;
    logic [XLEN-1:0] i_data_wdata;
    logic [2:0]      i_funct3;
    logic            i_read_write;
    logic            or_inst_ack;
    logic [XLEN-1:0] or_inst_data;
    logic            or_data_ack;
    logic [XLEN-1:0] or_data_rdata;
    logic            or_data_err;
    logic            or_mem_req;
    logic [XLEN-1:0] or_mem_addr;
    logic            or_mem_we;
    logic [3:0]      or_mem_be;
    logic [XLEN-1:0] or_mem_wdata;
    logic            i_mem_ack;
    logic [XLEN-1:0] i_mem_rdata;

    modport slave (
        input  i_inst_req, i_inst_addr, i_data_req, i_data_addr, i_data_wdata,
               i_funct3, i_read_write, i_mem_ack, i_mem_rdata,
        output or_inst_ack, or_inst_data, or_data_ack, or_data_rdata, or_data_err,
               or_mem_req, or_mem_addr, or_mem_we, or_mem_be, or_mem_wdata
    );

    modport master (
        output i_inst_req, i_inst_addr, i_data_req, i_data_addr, i_data_wdata,
               i_funct3, i_read_write, i_mem_ack, i_mem_rdata,
        input  or_inst_ack, or_inst_data, or_data_ack, or_data_rdata, or_data_err,
               or_mem_req, or_mem_addr, or_mem_we, or_mem_be, or_mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Merges the core's fetch and data request ports onto one shared memory bus.
// Data accesses are turned into word-aligned transfers with byte enables and
// load data is returned sign/zero extended. Bad requests, misaligned accesses
// and bus timeouts are answered with an error acknowledge.
module mem_arbiter #(
    parameter int XLEN        = 32,
    parameter int DATA_STREAK = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    mem_arbiter_if.slave bus
);
    localparam int            SW         = (DATA_STREAK < 1) ? 1 : $clog2(DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(DATA_STREAK);
    localparam logic [7:0]    TMO_LAST   = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, INST, DATA, DONE} state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic [7:0]      tmo_q, tmo_d;
    logic            mem_req_q, mem_req_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic            mem_we_q, mem_we_d;
    logic [3:0]      mem_be_q, mem_be_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      lane_q, lane_d;
    logic            inst_ack_q, inst_ack_d;
    logic            data_ack_q, data_ack_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] inst_data_q, inst_data_d;
    logic [XLEN-1:0] data_rdata_q, data_rdata_d;

    logic data_win;
    logic bad_data;

    // Codes that do not name a valid access for the given direction.
    function automatic logic is_illegal(input logic [2:0] f3, input logic rw);
        if (rw) return (f3 > 3'b010);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return lo[0];
            2'b10:   return (lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lo;
            2'b01:   return 4'b0011 << {lo[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the right-justified store value across every lane so the
    // byte enables alone select where it lands.
    function automatic logic [XLEN-1:0] store_data(input logic [2:0] f3, input logic [XLEN-1:0] wd);
        case (f3[1:0])
            2'b00:   return {(XLEN/8){wd[7:0]}};
            2'b01:   return {(XLEN/16){wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    // Pick the addressed byte/half out of the bus word and extend it.
    function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] word,
                                                 input logic [2:0] f3,
                                                 input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {lane, 3'b000});
        h = 16'(word >> {lane[1], 4'b0000});
        case (f3)
            3'b000:  return {{(XLEN-8){b[7]}}, b};
            3'b001:  return {{(XLEN-16){h[15]}}, h};
            3'b100:  return {{(XLEN-8){1'b0}}, b};
            3'b101:  return {{(XLEN-16){1'b0}}, h};
            default: return word;
        endcase
    endfunction

    // Data wins unless the fetch port has been starved for a full streak.
    assign data_win = bus.i_data_req && !(bus.i_inst_req && (streak_q == STREAK_MAX));
    assign bad_data = is_illegal(bus.i_funct3, bus.i_read_write) ||
                      is_misaligned(bus.i_funct3, bus.i_data_addr[1:0]);

    // Next-state, grant and response formatting.
    always_comb begin
        state_d      = state_q;
        streak_d     = streak_q;
        tmo_d        = tmo_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        f3_d         = f3_q;
        lane_d       = lane_q;
        inst_ack_d   = 1'b0;
        data_ack_d   = 1'b0;
        err_d        = err_q;
        inst_data_d  = inst_data_q;
        data_rdata_d = data_rdata_q;

        case (state_q)
            IDLE: begin
                if (data_win) begin
                    streak_d = bus.i_inst_req ? streak_q + SW'(1) : '0;
                    if (bad_data) begin
                        state_d      = DONE;
                        data_ack_d   = 1'b1;
                        err_d        = 1'b1;
                        data_rdata_d = '0;
                    end else begin
                        state_d     = DATA;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = {bus.i_data_addr[XLEN-1:2], 2'b00};
                        mem_we_d    = bus.i_read_write;
                        mem_be_d    = bus.i_read_write ? store_be(bus.i_funct3, bus.i_data_addr[1:0]) : 4'b1111;
                        mem_wdata_d = bus.i_read_write ? store_data(bus.i_funct3, bus.i_data_wdata) : '0;
                        f3_d        = bus.i_funct3;
                        lane_d      = bus.i_data_addr[1:0];
                        tmo_d       = '0;
                    end
                end else if (bus.i_inst_req) begin
                    streak_d    = '0;
                    state_d     = INST;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = bus.i_inst_addr & ~XLEN'(3);
                    mem_we_d    = 1'b0;
                    mem_be_d    = 4'b1111;
                    mem_wdata_d = '0;
                    tmo_d       = '0;
                end
            end
            INST, DATA: begin
                // An ack on the final timeout cycle still counts as success.
                if (bus.i_mem_ack) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b0;
                    if (state_q == INST) begin
                        inst_ack_d  = 1'b1;
                        inst_data_d = bus.i_mem_rdata;
                    end else begin
                        data_ack_d   = 1'b1;
                        data_rdata_d = mem_we_q ? '0 : fmt_load(bus.i_mem_rdata, f3_q, lane_q);
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (state_q == INST) begin
                        inst_ack_d  = 1'b1;
                        inst_data_d = '0;
                    end else begin
                        data_ack_d   = 1'b1;
                        data_rdata_d = '0;
                    end
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears every output.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            streak_q     <= '0;
            tmo_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            f3_q         <= '0;
            lane_q       <= '0;
            inst_ack_q   <= 1'b0;
            data_ack_q   <= 1'b0;
            err_q        <= 1'b0;
            inst_data_q  <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            tmo_q        <= tmo_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            f3_q         <= f3_d;
            lane_q       <= lane_d;
            inst_ack_q   <= inst_ack_d;
            data_ack_q   <= data_ack_d;
            err_q        <= err_d;
            inst_data_q  <= inst_data_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign bus.or_inst_ack   = inst_ack_q;
    assign bus.or_inst_data  = inst_data_q;
    assign bus.or_data_ack   = data_ack_q;
    assign bus.or_data_rdata = data_rdata_q;
    assign bus.or_data_err   = err_q;
    assign bus.or_mem_req    = mem_req_q;
    assign bus.or_mem_addr   = mem_addr_q;
    assign bus.or_mem_we     = mem_we_q;
    assign bus.or_mem_be     = mem_be_q;
    assign bus.or_mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: randomized and directed requests, a memory responder
// with programmable latency, and scoreboard monitors for bus and responses.
module tb_mem_arbiter;
    localparam int XLEN        = 32;
    localparam int DATA_STREAK = 4;
    localparam int TIMEOUT     = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.XLEN(XLEN)) bus ();

    mem_arbiter #(.XLEN(XLEN), .DATA_STREAK(DATA_STREAK), .TIMEOUT(TIMEOUT)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    bus_t  bus_iq[$];
    bus_t  bus_dq[$];
    resp_t inst_q[$];
    resp_t data_q[$];
    bit    grant_log[$];

    logic [31:0] mem [bit [31:0]];
    int n_checks = 0;
    int n_fail   = 0;
    int mem_lat  = 1;
    bit mem_mute = 0;
    bit force_ack = 0;
    int last_req_len = 0;
    int ack_cnt = 0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        bit [31:0] k;
        k = {a[31:2], 2'b00};
        if (!mem.exists(k)) mem[k] = $urandom;
        return mem[k];
    endfunction

    // Memory: acks mem_lat cycles after the request is seen, unless muted.
    initial begin : responder
        int lat_cnt;
        lat_cnt = 0;
        bus.i_mem_ack = 1'b0;
        bus.i_mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            bus.i_mem_ack = force_ack;
            if (bus.or_mem_req && !mem_mute) begin
                if (lat_cnt >= mem_lat) begin
                    bus.i_mem_ack = 1'b1;
                    bus.i_mem_rdata = mem_word(bus.or_mem_addr);
                    lat_cnt = 0;
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // Bus monitor: new transfers against expectations, then stability.
    initial begin : bus_mon
        bit   prev_req;
        bit   use_d;
        int   len;
        bus_t cur;
        bus_t e;
        prev_req = 0;
        len = 0;
        forever begin
            @(negedge clk);
            if (bus.or_mem_req) begin
                if (!prev_req) begin
                    cur.addr = bus.or_mem_addr; cur.we = bus.or_mem_we;
                    cur.be = bus.or_mem_be; cur.wdata = bus.or_mem_wdata;
                    len = 1;
                    if (bus_iq.size() == 0 && bus_dq.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_req: got addr %h, expected no bus request", cur.addr);
                    end else begin
                        if (bus_iq.size() == 0) use_d = 1;
                        else if (bus_dq.size() == 0) use_d = 0;
                        else use_d = cur.addr[15];
                        e = use_d ? bus_dq.pop_front() : bus_iq.pop_front();
                        grant_log.push_back(use_d);
                        chk("bus_addr", cur.addr, e.addr);
                        chk("bus_we", 32'(cur.we), 32'(e.we));
                        chk("bus_be", 32'(cur.be), 32'(e.be));
                        if (e.we) chk("bus_wdata", cur.wdata, e.wdata);
                    end
                end else begin
                    len++;
                    chk("bus_stable_addr", bus.or_mem_addr, cur.addr);
                    chk("bus_stable_ctl", {bus.or_mem_we, bus.or_mem_be, bus.or_mem_wdata[26:0]},
                        {cur.we, cur.be, cur.wdata[26:0]});
                end
            end else if (prev_req) begin
                last_req_len = len;
            end
            prev_req = bus.or_mem_req;
        end
    end

    // Response monitor: every ack pops the matching port's expectation.
    initial begin : resp_mon
        resp_t e;
        forever begin
            @(negedge clk);
            if (bus.or_inst_ack) begin
                ack_cnt++;
                if (inst_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_inst_ack: got data %h, expected no ack", bus.or_inst_data);
                end else begin
                    e = inst_q.pop_front();
                    chk("inst_data", bus.or_inst_data, e.data);
                    chk("inst_err", 32'(bus.or_data_err), 32'(e.err));
                end
            end
            if (bus.or_data_ack) begin
                ack_cnt++;
                if (data_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_data_ack: got data %h, expected no ack", bus.or_data_rdata);
                end else begin
                    e = data_q.pop_front();
                    chk("data_rdata", bus.or_data_rdata, e.data);
                    chk("data_err", 32'(bus.or_data_err), 32'(e.err));
                end
            end
        end
    end

    task automatic wait_ack(input bit is_data, output logic [31:0] d, output logic e);
        int n;
        bit got;
        n = 0;
        got = 0;
        while (!got && n < 200) begin
            @(posedge clk); #1;
            n++;
            got = is_data ? bus.or_data_ack : bus.or_inst_ack;
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL ack_wait: got no ack after %0d cycles, expected ack (port %0d)", n, is_data);
        end
        d = is_data ? bus.or_data_rdata : bus.or_inst_data;
        e = bus.or_data_err;
    endtask

    task automatic do_inst(input logic [31:0] a, input int lat, input bit keep);
        bus_t b;
        resp_t r;
        logic [31:0] d;
        logic e;
        mem_lat = lat;
        b.addr = a & 32'hFFFF_FFFC; b.we = 0; b.be = 4'hF; b.wdata = '0;
        r.err = (lat >= TIMEOUT);
        r.data = r.err ? 32'h0 : mem_word(a);
        bus_iq.push_back(b);
        inst_q.push_back(r);
        bus.i_inst_addr = a;
        bus.i_inst_req = 1'b1;
        wait_ack(0, d, e);
        if (!keep) bus.i_inst_req = 1'b0;
    endtask

    // Reference: derive bus transfer and response from size/sign rules.
    task automatic do_data(input logic [2:0] f3, input logic rw, input logic [31:0] a,
                           input logic [31:0] wd, input int lat, input bit keep,
                           output logic [31:0] d, output logic e);
        bus_t  b;
        resp_t r;
        int size, off, bits;
        bit legal;
        logic [31:0] v, mask;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off = int'(a[1:0]);
        legal = rw ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal || (off % size) != 0) begin
            r.data = '0; r.err = 1;
        end else begin
            b.addr = a - 32'(off);
            b.we = rw;
            b.wdata = '0;
            if (rw) begin
                b.be = 4'(((1 << size) - 1) << off);
                for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
            end else begin
                b.be = 4'hF;
            end
            bus_dq.push_back(b);
            if (lat >= TIMEOUT) begin
                r.data = '0; r.err = 1;
            end else if (rw) begin
                r.data = '0; r.err = 0;
            end else begin
                bits = 8 * size;
                v = mem_word(a) >> (8 * off);
                if (size < 4) begin
                    mask = (32'h1 << bits) - 1;
                    v = v & mask;
                    if (!f3[2] && v[bits-1]) v = v | ~mask;
                end
                r.data = v; r.err = 0;
            end
        end
        data_q.push_back(r);
        mem_lat = lat;
        bus.i_funct3 = f3;
        bus.i_read_write = rw;
        bus.i_data_addr = a;
        bus.i_data_wdata = wd;
        bus.i_data_req = 1'b1;
        wait_ack(1, d, e);
        if (!keep) bus.i_data_req = 1'b0;
    endtask

    initial begin : main
        logic [31:0] d;
        logic e;
        bit exp_g[10];
        bus_t b;
        int n;
        bus.i_inst_req = 0; bus.i_inst_addr = '0;
        bus.i_data_req = 0; bus.i_data_addr = '0; bus.i_data_wdata = '0;
        bus.i_funct3 = '0; bus.i_read_write = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", 32'(bus.or_mem_req), 0);
        chk("rst_acks", {bus.or_inst_ack, bus.or_data_ack, bus.or_data_err}, 0);
        chk("rst_mem_addr", bus.or_mem_addr, 0);
        chk("rst_mem_be_we", {bus.or_mem_be, bus.or_mem_we}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases from the functional description.
        mem[32'h104] = 32'h00A0_0093;
        mem[32'h200] = 32'h80FF_1234;
        do_inst(32'h104, 2, 0);
        do_data(3'b000, 0, 32'h203, '0, 1, 0, d, e); chk("lb", d, 32'hFFFF_FF80);
        do_data(3'b100, 0, 32'h203, '0, 0, 0, d, e); chk("lbu", d, 32'h0000_0080);
        do_data(3'b101, 0, 32'h202, '0, 3, 0, d, e); chk("lhu", d, 32'h0000_80FF);
        do_data(3'b000, 1, 32'h301, 32'hAB, 1, 0, d, e); chk("sb_rdata", d, 0);
        do_data(3'b001, 1, 32'h302, 32'h1234, 1, 0, d, e);
        do_data(3'b010, 0, 32'h102, '0, 1, 0, d, e); chk("lw_misaligned_err", 32'(e), 1);
        do_data(3'b011, 0, 32'h100, '0, 1, 0, d, e); chk("ld_illegal_err", 32'(e), 1);

        // Both ports held continuously.
        repeat (2) @(posedge clk);
        #1;
        grant_log.delete();
        exp_g = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        fork
            begin
                do_inst(32'h1000, 1, 1);
                do_inst(32'h1004, 1, 0);
            end
            begin
                logic [31:0] d2;
                logic e2;
                for (int i = 0; i < 8; i++)
                    do_data(3'b010, 0, 32'h8000 + 32'(4 * i), '0, 1, (i < 7), d2, e2);
            end
        join
        @(negedge clk);
        chk("grant_count", grant_log.size(), 10);
        for (int i = 0; i < 10; i++)
            if (i < grant_log.size()) chk($sformatf("grant_%0d", i), 32'(grant_log[i]), 32'(exp_g[i]));

        // Timeout, and an ack landing on the final timeout cycle.
        @(posedge clk); #1;
        do_data(3'b010, 0, 32'h8040, '0, TIMEOUT, 0, d, e);
        @(negedge clk);
        chk("tmo_err", 32'(e), 1);
        chk("tmo_req_len", last_req_len, TIMEOUT);
        do_data(3'b010, 0, 32'h8044, '0, TIMEOUT - 1, 0, d, e);
        chk("tmo_edge_ok", 32'(e), 0);
        do_inst(32'h0204, TIMEOUT, 0);

        // Reset in the middle of a transfer, then a stray ack.
        @(posedge clk); #1;
        mem_mute = 1;
        b.addr = 32'h8100; b.we = 0; b.be = 4'hF; b.wdata = '0;
        bus_dq.push_back(b);
        bus.i_funct3 = 3'b010; bus.i_read_write = 0;
        bus.i_data_addr = 32'h8100; bus.i_data_req = 1'b1;
        n = 0;
        while (!bus.or_mem_req && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mid_req_up", 32'(bus.or_mem_req), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_req", 32'(bus.or_mem_req), 0);
        chk("mid_rst_addr", bus.or_mem_addr, 0);
        chk("mid_rst_be_we", {bus.or_mem_be, bus.or_mem_we}, 0);
        chk("mid_rst_acks", {bus.or_inst_ack, bus.or_data_ack, bus.or_data_err}, 0);
        rst_n = 1'b1;
        bus.i_data_req = 1'b0;
        mem_mute = 0;
        ack_cnt = 0;
        @(posedge clk); #1;
        force_ack = 1;
        @(posedge clk); #1;
        force_ack = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("late_ack_ignored", ack_cnt, 0);

        // Randomized single-port traffic.
        for (int i = 0; i < 80; i++) begin
            int lat;
            lat = ($urandom_range(0, 9) == 0) ? TIMEOUT + $urandom_range(0, 2) : $urandom_range(0, 4);
            if ($urandom_range(0, 3) == 0)
                do_inst(32'($urandom_range(0, 32'h7FFF)), lat, 0);
            else
                do_data(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                        32'h8000 + 32'($urandom_range(0, 255)), $urandom, lat, 0, d, e);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("inst_q_drained", inst_q.size(), 0);
        chk("data_q_drained", data_q.size(), 0);
        chk("bus_q_drained", bus_iq.size() + bus_dq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Sits directly downstream of the cpu core. It merges the core's instruction-fetch request port and data-memory request port onto one shared single-port memory bus. It converts funct3-encoded byte/half/word accesses into word-aligned bus transfers with byte enables, and returns sign- or zero-extended load data. It also flags misaligned accesses, illegal funct3 codes and bus timeouts.

Parameters:
XLEN, 32, data/address width
DATA_STREAK, 4, maximum consecutive data grants allowed while an instruction request is pending
TIMEOUT, 255, cycles to wait for i_mem_ack before aborting; range 1..255

Ports:
i_clk  in  1  CPU clock
i_rst_n  in  1  synchronous active-low reset
i_inst_req  in  1  fetch request; held high until or_inst_ack
i_inst_addr  in  XLEN  fetch byte address
i_data_req  in  1  data request; held high until or_data_ack
i_data_addr  in  XLEN  data byte address
i_data_wdata  in  XLEN  store data, right-justified
i_funct3  in  3  access size/sign code
i_read_write  in  1  0 = load, 1 = store
or_inst_ack  out  1  one-cycle fetch completion pulse
or_inst_data  out  XLEN  fetched word, valid with or_inst_ack
or_data_ack  out  1  one-cycle data completion pulse
or_data_rdata  out  XLEN  formatted load data, valid with or_data_ack
or_data_err  out  1  misaligned, illegal funct3 or timeout; valid with either ack
or_mem_req  out  1  bus request
or_mem_addr  out  XLEN  word-aligned address; bits [1:0] = 0
or_mem_we  out  1  bus write enable
or_mem_be  out  4  byte enables
or_mem_wdata  out  XLEN  lane-aligned write data
i_mem_ack  in  1  bus completion
i_mem_rdata  in  XLEN  bus read word, valid with i_mem_ack

Behaviour:
- Reset: all outputs are 0, state = IDLE, streak counter = 0, timeout counter = 0. Reset mid-transfer drops or_mem_req on the next edge. An i_mem_ack that arrives later while in IDLE is ignored.
- FSM states are IDLE, INST, DATA, DONE.
- IDLE, grant decision:
  - data wins if i_data_req is high, unless i_inst_req is high and streak = DATA_STREAK; inst then wins.
  - inst grant clears streak. Data grant increments streak if i_inst_req is high, otherwise clears it.
- Illegal or misaligned data request, checked in IDLE:
  - illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
  - misaligned: half with addr[0] = 1; word with addr[1:0] != 0.
  - response: go straight to DONE with or_data_ack = 1, or_data_err = 1, rdata = 0. No bus cycle is issued.
- On grant, the FSM moves to INST or DATA and registers or_mem_req = 1 plus the address, we, be and wdata. These stay stable until ack or timeout. Latency is 1 cycle from req to or_mem_req.
- Instruction fetch: be = 1111, we = 0, addr = i_inst_addr & ~3.
- Stores:
  - SB: be = 0001 << addr[1:0], wdata = byte replicated x4.
  - SH: be = 0011 << (2*addr[1]), wdata = half replicated x2.
  - SW: be = 1111.
- Loads: we = 0, be = 1111. Byte/half selected by addr[1:0]/addr[1]. 000 and 001 sign-extend; 100 and 101 zero-extend; 010 passes through.
- i_mem_ack in INST or DATA:
  - drop or_mem_req on the next edge, register formatted data, enter DONE.
  - the matching ack is high for exactly the DONE cycle.
  - store ack returns rdata = 0.
- Timeout: the counter starts at 0 on entry to INST/DATA. If i_mem_ack has not arrived by TIMEOUT cycles, drop the request, enter DONE with err = 1 and data = 0. An ack arriving on the same cycle as the timeout counts as success.
- DONE lasts one cycle, ignores all requests and returns to IDLE. Requesters must deassert or change their request during the ack cycle, so back-to-back grants are spaced at least 1 IDLE cycle apart.
- i_mem_ack while in IDLE or DONE is ignored.

Test Plan:
- Fetch at addr 0x104, memory returns 0x00A00093 after 2 cycles -> or_mem_addr = 0x104, be = 1111; or_inst_ack pulses once with 0x00A00093, err = 0.
- LB at 0x203, mem word 0x80FF1234 -> or_data_rdata = 0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x202 -> 0x000080FF.
- SB of 0x000000AB to 0x301 -> or_mem_addr = 0x300, be = 0010, wdata = 0xABABABAB, we = 1. SH to 0x302 -> be = 1100.
- LW at 0x102 -> or_data_ack with err = 1 and no or_mem_req. funct3 = 011 load -> same response.
- Both requests held continuously, DATA_STREAK = 4 -> grant order D,D,D,D,I,D,D,D,D,I.
- Memory never acks, TIMEOUT = 8 -> or_mem_req drops after 8 cycles and or_data_ack pulses with err = 1. Separately, assert reset mid-transfer -> all outputs 0 next edge, and a late i_mem_ack produces no ack.
